// File: rtl/moore_0101_pkg.sv
// ---------------------------------------------------------------------------
// moore_0101_pkg : state encoding and counter width for the 0101 detector
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package moore_0101_pkg;

  typedef enum logic [2:0] {
    S0 = 3'b000,
    S1 = 3'b001,
    S2 = 3'b010,
    S3 = 3'b011,
    S4 = 3'b100
  } state_t;

  localparam int c_cnt_width = 8;

endpackage

`default_nettype wire

// File: rtl/moore_0101_cnt.sv
// ---------------------------------------------------------------------------
// moore_0101_cnt : saturating detection counter (built only with MOORE_0101_CNT_EN)
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

`ifdef MOORE_0101_CNT_EN
module moore_0101_cnt
  import moore_0101_pkg::*;
(
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   hit,
  output logic [c_cnt_width-1:0] count
);

  localparam logic [c_cnt_width-1:0] c_max = '1;

  logic [c_cnt_width-1:0] r_count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (hit && (r_count != c_max)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule
`endif

`default_nettype wire

// File: rtl/moore_0101.sv
// ---------------------------------------------------------------------------
// moore_0101 : Moore FSM detecting serial 0,1,0,1; optional counter via MOORE_0101_CNT_EN
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module moore_0101
  import moore_0101_pkg::*;
#(
  parameter int OVERLAP = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   in,
  output logic                   out,
  output logic [2:0]             y
`ifdef MOORE_0101_CNT_EN
  ,
  output logic [c_cnt_width-1:0] match_count
`endif
);

  state_t r_state;
  state_t w_next;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S0;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = S0;
    case (r_state)
      S0:      w_next = in ? S0 : S1;
      S1:      w_next = in ? S2 : S1;
      S2:      w_next = in ? S0 : S3;
      S3:      w_next = in ? S4 : S1;
      // Overlap keeps the trailing "01" of the match as a new "010" prefix once a 0 follows
      S4:      w_next = in ? S0 : ((OVERLAP != 0) ? S3 : S1);
      default: w_next = S0;
    endcase
  end

  assign out = (r_state == S4);
  assign y   = r_state;

`ifdef MOORE_0101_CNT_EN
  logic w_hit;
  assign w_hit = (w_next == S4);

  moore_0101_cnt u_cnt (
    .clock (clock),
    .reset (reset),
    .hit   (w_hit),
    .count (match_count)
  );
`endif

endmodule

`default_nettype wire

// File: tb/tb_moore_0101.sv
// ---------------------------------------------------------------------------
// tb_moore_0101 : directed checks of both overlap modes side by side
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_moore_0101;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       din   = 1'b0;
  logic       out1, out0;
  logic [2:0] y1, y0;
`ifdef MOORE_0101_CNT_EN
  logic [7:0] cnt1, cnt0;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  moore_0101 #(.OVERLAP(1)) dut1 (
    .clock(clk), .reset(rst_n), .in(din), .out(out1), .y(y1)
`ifdef MOORE_0101_CNT_EN
    , .match_count(cnt1)
`endif
  );

  moore_0101 #(.OVERLAP(0)) dut0 (
    .clock(clk), .reset(rst_n), .in(din), .out(out0), .y(y0)
`ifdef MOORE_0101_CNT_EN
    , .match_count(cnt0)
`endif
  );

  typedef struct {
    logic       din;
    logic [2:0] y1;
    logic [2:0] y0;
  } vec_t;

  vec_t tbl [12];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_state(input string name, input logic [2:0] e1, input logic [2:0] e0);
    check({name, " y1"},   {5'd0, y1},   {5'd0, e1});
    check({name, " out1"}, {7'd0, out1}, {7'd0, (e1 == 3'b100)});
    check({name, " y0"},   {5'd0, y0},   {5'd0, e0});
    check({name, " out0"}, {7'd0, out0}, {7'd0, (e0 == 3'b100)});
  endtask

  task automatic step(input logic b);
    din = b;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    #1;
    check_state("async reset", 3'd0, 3'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int det1, det0;

    // 0,1,0,1,1,0,1,0,1,0,1,1 : overlap pulses after bits 4,9,11; non-overlap after 4,9
    tbl[0]  = '{1'b0, 3'd1, 3'd1};
    tbl[1]  = '{1'b1, 3'd2, 3'd2};
    tbl[2]  = '{1'b0, 3'd3, 3'd3};
    tbl[3]  = '{1'b1, 3'd4, 3'd4};
    tbl[4]  = '{1'b1, 3'd0, 3'd0};
    tbl[5]  = '{1'b0, 3'd1, 3'd1};
    tbl[6]  = '{1'b1, 3'd2, 3'd2};
    tbl[7]  = '{1'b0, 3'd3, 3'd3};
    tbl[8]  = '{1'b1, 3'd4, 3'd4};
    tbl[9]  = '{1'b0, 3'd3, 3'd1};
    tbl[10] = '{1'b1, 3'd4, 3'd2};
    tbl[11] = '{1'b1, 3'd0, 3'd0};

    // Startup reset: held low across a clock edge with in=0
    #1;
    check_state("startup reset", 3'd0, 3'd0);
    #8;
    check_state("reset across edge", 3'd0, 3'd0);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      step(tbl[i].din);
      check_state($sformatf("vec %0d", i), tbl[i].y1, tbl[i].y0);
    end

    // Reset in S3 discards the partial match
    step(1'b0); step(1'b1); step(1'b0);
    check_state("reach S3", 3'd3, 3'd3);
    reset_pulse();
    step(1'b1);
    check_state("after reset in=1", 3'd0, 3'd0);

    // 0101010: two detections with overlap, one without
    det1 = 0;
    det0 = 0;
    for (int i = 0; i < 7; i++) begin
      step(i[0]);
      det1 += int'(out1);
      det0 += int'(out0);
    end
    check("0101010 det overlap", det1[7:0], 8'd2);
    check("0101010 det nonoverlap", det0[7:0], 8'd1);
    check_state("0101010 end", 3'd3, 3'd3);

    // Long runs of 1s then 0s never detect
    reset_pulse();
    for (int i = 0; i < 10; i++) begin
      step(1'b1);
      check_state("held 1", 3'd0, 3'd0);
    end
    for (int i = 0; i < 10; i++) begin
      step(1'b0);
      check_state("held 0", 3'd1, 3'd1);
    end

`ifdef MOORE_0101_CNT_EN
    reset_pulse();
    check("cnt1 reset", cnt1, 8'd0);
    check("cnt0 reset", cnt0, 8'd0);
    for (int p = 0; p < 300; p++) begin
      step(1'b0); step(1'b1); step(1'b0); step(1'b1);
      if (p == 0) begin
        check("cnt1 first", cnt1, 8'd1);
        check("cnt0 first", cnt0, 8'd1);
      end else if (p == 1) begin
        check("cnt1 second", cnt1, 8'd3);
        check("cnt0 second", cnt0, 8'd2);
      end
    end
    check("cnt1 saturated", cnt1, 8'd255);
    check("cnt0 saturated", cnt0, 8'd255);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/moore_0101.md
MOORE_0101 -- requirements
Module: moore_0101

Interface
REQ-001 Parameter: OVERLAP, default 1, meaning 1 = overlapping detection, 0 = non-overlapping detection.
REQ-002 Port: clock  input  1  rising-edge system clock.
REQ-003 Port: reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-004 Port: in  input  1  serial data bit, sampled on each rising clock edge.
REQ-005 Port: out  output  1  detection flag, 1 while FSM is in state S4.
REQ-006 Port: y  output  3  current state register, for debug/observation.
REQ-007 Port: match_count  output  8  saturating detection count; present only when MOORE_0101_CNT_EN is defined.

Function
REQ-008 The block SHALL be a Moore FSM detecting serial sequence 0,1,0,1 (first bit received first); out SHALL depend only on y.
REQ-009 States and encodings SHALL be: S0=000 (nothing matched), S1=001 ("0"), S2=010 ("01"), S3=011 ("010"), S4=100 ("0101" detected).
REQ-010 Transitions (in=0 / in=1) SHALL be: S0 -> S1/S0; S1 -> S1/S2; S2 -> S3/S0; S3 -> S1/S4.
REQ-011 From S4 with OVERLAP=1, transitions SHALL be in=0 -> S3 and in=1 -> S0.
REQ-012 From S4 with OVERLAP=0, transitions SHALL be in=0 -> S1 and in=1 -> S0.
REQ-013 out SHALL be 1 iff y==S4; it is a combinational decode of the state register with no extra register stage.
REQ-014 Latency: out SHALL rise in the clock cycle after the edge that samples the final 1, and SHALL last exactly one cycle per detection.
REQ-015 Unused encodings 101/110/111 SHALL transition to S0 on the next edge and SHALL drive out=0.
REQ-016 With OVERLAP=1, the input 0101010 SHALL yield two detections.

Reset
REQ-017 While reset=0, y SHALL be S0 and out SHALL be 0 immediately, independent of clock.
REQ-018 Reset asserted mid-sequence SHALL discard any partial match; detection restarts from S0 after release.
REQ-019 The first edge after reset release SHALL sample in normally.

Configuration
REQ-020 Macro MOORE_0101_CNT_EN defined: match_count SHALL exist, increment by 1 on each edge where next state is S4, saturate at 255, and reset asynchronously to 0.
REQ-021 Macro MOORE_0101_CNT_EN undefined: the match_count port and its logic SHALL be absent; all other behaviour is unchanged.

Structure
REQ-022 Package moore_0101_pkg SHALL hold the state typedef (3-bit enum S0..S4) and the width constant for match_count.
REQ-023 The design SHALL be a single module with separate state-register, next-state and output-decode processes; the optional counter SHALL be the sub-module moore_0101_cnt.

Verification
REQ-024 Scenario: reset=0 for 10 ns at startup -> y=000, out=0 throughout the reset.
REQ-025 Scenario: in=0,1,0,1 on successive edges -> y steps 001, 010, 011, 100; out=1 for exactly one cycle after the 4th edge.
REQ-026 Scenario: in=0,1,0,1,1,0,1,0,1,0,1,1 with OVERLAP=1 -> out pulses 3 times (after bits 4, 9 and 11); with OVERLAP=0 -> out pulses 2 times (after bits 4 and 9).
REQ-027 Scenario: reset=0 asserted while y=011, then in=1 after release -> y=000, no detection.
REQ-028 Scenario: in held at 1 for 10 cycles, then held at 0 for 10 cycles -> out stays 0; y=000, then y=001.
REQ-029 Scenario: with MOORE_0101_CNT_EN defined, 300 back-to-back 0101 patterns -> match_count=255 (saturated).
